// File: rtl/reloj_ctrl.sv
// reloj_ctrl: sequencer for an HH:MM:SS clock built from six external BCD digit counters.
// It provides a 1 Hz prescaler, button edge detectors, a RUN/SET_HR/SET_MIN FSM and registered inc/clr strobes.
module reloj_ctrl #(
  parameter int TICK_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic [3:0] tc,
  input  logic [1:0] h_hi,
  input  logic [3:0] h_lo,
  output logic [5:0] inc,
  output logic [5:0] clr,
  output logic [1:0] mode,
  output logic       blink
);

  localparam int            CW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(TICK_DIV / 2);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0]    mode_sr, inc_sr;  // {prev, sync2, sync1}
  logic          mode_edge, inc_edge, tick, reload, hour_step;
  logic [5:0]    inc_nx, clr_nx;

  assign mode_edge = mode_sr[1] & ~mode_sr[2];
  assign inc_edge  = inc_sr[1] & ~inc_sr[2];
  assign tick      = (cnt == CNT_LAST);

  // NOTE: sequential state uses <= so every flop samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= RUN;
      cnt     <= '0;
      mode_sr <= '0;
      inc_sr  <= '0;
      inc     <= '0;
      clr     <= '0;
    end else begin
      state   <= state_nx;
      mode_sr <= {mode_sr[1:0], btn_mode};
      inc_sr  <= {inc_sr[1:0], btn_inc};
      inc     <= inc_nx;
      clr     <= clr_nx;
      if (reload || tick) cnt <= '0;
      else                cnt <= cnt + CW'(1);
    end
  end

  always_comb begin
    // NOTE: every signal gets a default first, so no path can leave one unassigned and infer a latch.
    state_nx  = state;
    inc_nx    = '0;
    clr_nx    = '0;
    reload    = 1'b0;
    hour_step = 1'b0;
    case (state)
      RUN: begin
        if (tick) begin
          inc_nx[0] = 1'b1;
          inc_nx[1] = tc[0];
          inc_nx[2] = tc[0] & tc[1];
          inc_nx[3] = tc[0] & tc[1] & tc[2];
          hour_step = tc[0] & tc[1] & tc[2] & tc[3];
        end
        if (mode_edge) state_nx = SET_HR;
      end
      SET_HR: begin
        if (mode_edge)     state_nx  = SET_MIN;
        else if (inc_edge) hour_step = 1'b1;
      end
      SET_MIN: begin
        if (mode_edge) begin
          // Returning to RUN restarts the second from 00 with a fresh prescaler period.
          state_nx    = RUN;
          clr_nx[1:0] = 2'b11;
          reload      = 1'b1;
        end else if (inc_edge) begin
          inc_nx[2] = 1'b1;
          inc_nx[3] = tc[2];
        end
      end
      default: state_nx = RUN;
    endcase

    // Hours wrap 23 -> 00 by clearing both digits; otherwise units step and tens follow from 9.
    if (hour_step) begin
      if (h_hi == 2'd2 && h_lo == 4'd3) begin
        clr_nx[5:4] = 2'b11;
      end else begin
        inc_nx[4] = 1'b1;
        inc_nx[5] = (h_lo == 4'd9);
      end
    end
  end

  assign mode  = state;
  assign blink = (state != RUN) && (cnt < CNT_HALF);

endmodule

// File: tb/tb_reloj_ctrl.sv
// tb_reloj_ctrl: directed plus randomized bench; the time of day is kept as seconds and
// expected strobes are derived from which BCD digits change between the old and new time.
module tb_reloj_ctrl;

  localparam int TD  = 4;
  localparam int DAY = 86400;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_mode = 1'b0;
  logic       btn_inc = 1'b0;
  logic [3:0] tc;
  logic [1:0] h_hi;
  logic [3:0] h_lo;
  logic [5:0] inc, clr;
  logic [1:0] mode;
  logic       blink;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int         t_sec = 0;
  logic [1:0] st = 2'd0;
  int         since = 0;
  bit         last_tick;
  bit         qm[$];
  bit         qi[$];

  always #5 clk = ~clk;

  reloj_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .btn_mode(btn_mode), .btn_inc(btn_inc),
    .tc(tc), .h_hi(h_hi), .h_lo(h_lo),
    .inc(inc), .clr(clr), .mode(mode), .blink(blink)
  );

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] digs(input int t);
    int h, m, s;
    h = t / 3600;
    m = (t / 60) % 60;
    s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  // {clr, inc} needed to move the digit counters from time a to time b.
  function automatic logic [11:0] strobes(input int a, input int b);
    logic [23:0] da, db;
    logic [5:0]  ch;
    da = digs(a);
    db = digs(b);
    for (int i = 0; i < 6; i++) ch[i] = (da[4*i +: 4] != db[4*i +: 4]);
    if (a / 3600 == 23 && b / 3600 == 0) return {6'b110000, ch & 6'b001111};
    return {6'b000000, ch};
  endfunction

  task automatic drive_time();
    logic [23:0] d;
    d    = digs(t_sec);
    tc   = {d[15:12] == 4'd5, d[11:8] == 4'd9, d[7:4] == 4'd5, d[3:0] == 4'd9};
    h_lo = d[19:16];
    h_hi = d[21:20];
  endtask

  task automatic model_reset();
    st    = 2'd0;
    since = 0;
    qm    = '{1'b0, 1'b0, 1'b0, 1'b0};
    qi    = '{1'b0, 1'b0, 1'b0, 1'b0};
  endtask

  // One rising edge: predict, then compare #1 after the edge.
  task automatic step();
    logic [11:0] s;
    logic [5:0]  e_inc, e_clr;
    int          nt;
    bit          me, ie, reload;
    void'(qm.pop_front()); qm.push_back(btn_mode);
    void'(qi.pop_front()); qi.push_back(btn_inc);
    @(posedge clk);
    me        = qm[1] && !qm[0];
    ie        = qi[1] && !qi[0];
    last_tick = ((since % TD) == TD - 1);
    e_inc = '0; e_clr = '0; nt = t_sec; reload = 1'b0;
    case (st)
      2'd0: begin
        if (last_tick) begin
          nt = (t_sec + 1) % DAY;
          s  = strobes(t_sec, nt);
          {e_clr, e_inc} = s;
        end
        if (me) st = 2'd1;
      end
      2'd1: begin
        if (me) st = 2'd2;
        else if (ie) begin
          nt = ((t_sec / 3600 + 1) % 24) * 3600 + t_sec % 3600;
          s  = strobes(t_sec, nt);
          {e_clr, e_inc} = s;
        end
      end
      default: begin
        if (me) begin
          st = 2'd0; e_clr = 6'b000011; nt = t_sec - t_sec % 60; reload = 1'b1;
        end else if (ie) begin
          nt = (t_sec / 3600) * 3600 + (((t_sec / 60) % 60 + 1) % 60) * 60 + t_sec % 60;
          s  = strobes(t_sec, nt);
          {e_clr, e_inc} = s;
        end
      end
    endcase
    since = reload ? 0 : since + 1;
    #1;
    check("inc", 8'(inc), 8'(e_inc));
    check("clr", 8'(clr), 8'(e_clr));
    check("mode", 8'(mode), 8'(st));
    check("blink", 8'(blink), 8'((st != 2'd0) && ((since % TD) < TD / 2)));
    t_sec = nt;
    drive_time();
  endtask

  // Called just after a step; asserts rst between edges and checks the async clear.
  task automatic apply_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_inc", 8'(inc), 8'h00);
    check("rst_clr", 8'(clr), 8'h00);
    check("rst_mode", 8'(mode), 8'h00);
    check("rst_blink", 8'(blink), 8'h00);
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_tick();
    bit found = 1'b0;
    for (int k = 0; k < TD + 1 && !found; k++) begin
      step();
      found = last_tick;
    end
    check("tick_seen", 8'(found), 8'h01);
  endtask

  // Buttons held for one cycle; the resulting strobe/state is registered on the third edge.
  task automatic press(input bit m, input bit i);
    btn_mode = m; btn_inc = i;
    step();
    btn_mode = 1'b0; btn_inc = 1'b0;
    step();
    step();
  endtask

  initial begin
    int hi;
    t_sec = 0;
    drive_time();
    model_reset();
    apply_reset();

    // First tick four edges after release
    repeat (3) step();
    check("pre_tick_inc", 8'(inc), 8'h00);
    step();
    check("first_tick_inc", 8'(inc), 8'h01);

    // 19:59:59 -> 20:00:00
    t_sec = 19 * 3600 + 59 * 60 + 59; drive_time();
    wait_tick();
    check("t19_inc", 8'(inc), 8'h3f);
    check("t19_clr", 8'(clr), 8'h00);

    // 23:59:59 -> 00:00:00
    t_sec = 23 * 3600 + 59 * 60 + 59; drive_time();
    wait_tick();
    check("t23_inc", 8'(inc), 8'h0f);
    check("t23_clr", 8'(clr), 8'h30);

    // SET_HR, increment from 23
    press(1'b1, 1'b0);
    check("set_hr_mode", 8'(mode), 8'h01);
    t_sec = 23 * 3600 + 15 * 60 + 7; drive_time();
    press(1'b0, 1'b1);
    check("hr23_mode", 8'(mode), 8'h01);
    check("hr23_clr", 8'(clr), 8'h30);
    check("hr23_inc", 8'(inc), 8'h00);

    // SET_MIN with m_lo==9, then back to RUN
    press(1'b1, 1'b0);
    check("set_min_mode", 8'(mode), 8'h02);
    t_sec = 10 * 3600 + 29 * 60 + 15; drive_time();
    press(1'b0, 1'b1);
    check("min29_inc", 8'(inc), 8'h0c);
    check("min29_clr", 8'(clr), 8'h00);
    press(1'b1, 1'b0);
    check("exit_mode", 8'(mode), 8'h00);
    check("exit_clr", 8'(clr), 8'h03);

    // Simultaneous mode/inc in RUN, then blink duty in SET_HR
    press(1'b1, 1'b1);
    check("both_mode", 8'(mode), 8'h01);
    check("both_inc", 8'(inc), 8'h00);
    check("both_clr", 8'(clr), 8'h00);
    hi = 0;
    repeat (4) begin
      step();
      hi += int'(blink);
    end
    check("blink_duty", 8'(hi), 8'h02);

    // Reset while an hour strobe is on the outputs
    t_sec = 9 * 3600; drive_time();
    press(1'b0, 1'b1);
    check("hr09_inc", 8'(inc), 8'h30);
    apply_reset();

    // Randomized phase
    for (int c = 0; c < 400; c++) begin
      btn_mode = ($urandom_range(0, 11) == 0);
      btn_inc  = ($urandom_range(0, 3) == 0);
      if (c % 37 == 0) begin
        case ($urandom_range(0, 3))
          0:       t_sec = 23 * 3600 + 59 * 60 + 58;
          1:       t_sec = 9 * 3600 + 59 * 60 + 59;
          2:       t_sec = 12 * 3600 + 59 * 60 + 57;
          default: t_sec = $urandom_range(0, DAY - 1);
        endcase
        drive_time();
      end
      step();
      if (c == 200) apply_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
